// File: rtl/irq_dispatch.sv
// Interrupt dispatch: accepts a masked/NMI request at an instruction boundary,
// fetches the 16-bit handler address from the vector table and presents it to the CPU.
module irq_dispatch #(
  parameter logic [23:0] VECTOR_BASE = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cpu_irq,
  input  logic [4:0]  irq_vector,
  input  logic [1:0]  cpu_i01,
  input  logic        instr_boundary,
  input  logic        bus_ack,
  input  logic [7:0]  bus_data_in,
  output logic        bus_read,
  output logic [23:0] bus_address_out,
  output logic        irq_take,
  output logic        busy,
  output logic        target_valid,
  output logic [15:0] target_pc,
  output logic [1:0]  new_i01
);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  vec_q, vec_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  i01_q, i01_d;
  logic        take_q, take_d;

  logic [1:0]  level;
  logic        accept;
  logic [23:0] lo_addr;

  always_comb begin
    level = 2'd0;
    if (cpu_irq[3])      level = 2'd3;
    else if (cpu_irq[2]) level = 2'd2;
    else if (cpu_irq[1]) level = 2'd1;
  end

  // Level 3 is the NMI and bypasses the mask comparison.
  assign accept  = instr_boundary && (level != 2'd0) &&
                   ((level > cpu_i01) || (level == 2'd3));
  assign lo_addr = VECTOR_BASE + {18'd0, vec_q, 1'b0};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    lo_d    = lo_q;
    pc_d    = pc_q;
    i01_d   = i01_q;
    take_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d   = irq_vector;
          lvl_d   = level;
          take_d  = 1'b1;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        if (bus_ack) begin
          lo_d    = bus_data_in;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        // Target registers update on the way into DONE so they are valid with target_valid.
        if (bus_ack) begin
          pc_d    = {bus_data_in, lo_q};
          i01_d   = lvl_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      lvl_q   <= '0;
      lo_q    <= '0;
      pc_q    <= '0;
      i01_q   <= '0;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      lvl_q   <= lvl_d;
      lo_q    <= lo_d;
      pc_q    <= pc_d;
      i01_q   <= i01_d;
      take_q  <= take_d;
    end
  end

  always_comb begin
    bus_read        = 1'b0;
    bus_address_out = '0;
    unique case (state_q)
      RD_LO: begin
        bus_read        = 1'b1;
        bus_address_out = lo_addr;
      end
      RD_HI: begin
        bus_read        = 1'b1;
        bus_address_out = lo_addr + 24'd1;
      end
      default: ;
    endcase
  end

  assign irq_take     = take_q;
  assign busy         = (state_q != IDLE);
  assign target_valid = (state_q == DONE);
  assign target_pc    = pc_q;
  assign new_i01      = i01_q;

endmodule
